cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, ROB tag width; tag 0 is the empty tag.
REQ-002 SHALL have parameter DATA_W, default 32, result data width.
REQ-003 SHALL have parameter DEPTH, default 2, holding-FIFO entries per source (power of two, >=2).
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-007 SHALL have port clear  input  1  synchronous pipeline flush (mispredict).
REQ-008 SHALL have ports alu_valid, lsb_valid, br_valid  input  1 each  source result offered this cycle.
REQ-009 SHALL have ports alu_tag, lsb_tag, br_tag  input  TAG_W each  destination ROB tag of result.
REQ-010 SHALL have ports alu_data, lsb_data, br_data  input  DATA_W each  result value.
REQ-011 SHALL have ports alu_ready, lsb_ready, br_ready  output  1 each  source FIFO can accept this cycle.
REQ-012 SHALL have port tag_renew  output  TAG_W  registered broadcast tag to RS, LSB, ROB; 0 = no broadcast.
REQ-013 SHALL have port data_renew  output  DATA_W  registered broadcast data, valid when tag_renew != 0.

Function
REQ-014 Source order for arbitration SHALL be ALU=0, LSB=1, BR=2.
REQ-015 x_ready SHALL be combinational: rdy high, clear low, and FIFO_x count < DEPTH; it SHALL NOT depend on a same-cycle pop.
REQ-016 A push into FIFO_x SHALL occur on an edge where x_valid, x_ready are high and x_tag != 0; valid with tag 0 SHALL be dropped silently.
REQ-017 Each FIFO SHALL be in-order with wrap-around read/write pointers and a count of width clog2(DEPTH)+1.
REQ-018 Each cycle the arbiter SHALL grant exactly one non-empty FIFO, searching round-robin from pointer rr (0..2) upward, wrapping 2->0.
REQ-019 On a grant to source g, rr SHALL become (g+1) mod 3 at the edge; with no grant rr SHALL hold.
REQ-020 On a grant, the FIFO head SHALL be popped and tag_renew/data_renew SHALL take its tag/data at the same edge.
REQ-021 With no non-empty FIFO, tag_renew SHALL become 0 at the edge and data_renew SHALL hold.
REQ-022 Minimum latency: result pushed at edge N SHALL appear on tag_renew after edge N+1.
REQ-023 Simultaneous push and pop on the same FIFO SHALL both occur; count unchanged.
REQ-024 Throughput SHALL be one broadcast per cycle; no bubble while any FIFO is non-empty.
REQ-025 Starvation freedom: a non-empty FIFO SHALL be granted within 3 cycles.
REQ-026 clear high (with rdy high) SHALL, at the edge, empty all FIFOs, set rr=0, set tag_renew=0, and drop all inputs of that cycle; clear SHALL take precedence over push and pop.
REQ-027 rdy low SHALL hold FIFOs, rr, and outputs unchanged and force all x_ready low.
REQ-028 Same tag pushed from two sources SHALL NOT be checked; both SHALL be broadcast in grant order.

Reset
REQ-029 rst low SHALL immediately, independent of clk, set tag_renew=0, data_renew=0, rr=0, and all FIFO counts/pointers to 0.
REQ-030 During reset all x_ready SHALL be low; the first push SHALL be possible at the first rising edge after rst deasserts.
REQ-031 Reset asserted mid-operation SHALL discard all buffered results without broadcast.

Verification
REQ-032 Single ALU push of tag 5, data 0x1234 at edge N -> tag_renew=5, data_renew=0x1234 after edge N+1; tag_renew=0 after N+2.
REQ-033 ALU tag 1, LSB tag 2, BR tag 3 pushed on the same edge with rr=0 -> broadcasts 1,2,3 on three consecutive cycles; rr=0 afterwards.
REQ-034 Hold lsb_valid high with 3 results while ALU idle; push 2 entries, no pop -> lsb_ready low after DEPTH pushes; third result not taken until a pop.
REQ-035 All three FIFOs kept non-empty for 9 cycles -> grant sequence ALU,LSB,BR repeating; each source granted 3 times.
REQ-036 FIFOs holding 4 results, clear high for one cycle -> tag_renew=0 next cycle and no buffered tag broadcast afterwards.
REQ-037 rst pulsed low between edges while data buffered -> tag_renew=0 immediately; after release, no stale tag broadcast and alu_valid tag 7 broadcasts normally.

Source files
------------

// File: rtl/cdb_if.sv
// Result-bus bundle between the three execution sources and the CDB arbiter.
// A source result is taken on a rising edge where x_valid and x_ready are both high.
interface cdb_if #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
);
  logic              alu_valid;
  logic              lsb_valid;
  logic              br_valid;
  logic [TAG_W-1:0]  alu_tag;
  logic [TAG_W-1:0]  lsb_tag;
  logic [TAG_W-1:0]  br_tag;
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] lsb_data;
  logic [DATA_W-1:0] br_data;
  logic              alu_ready;
  logic              lsb_ready;
  logic              br_ready;
  logic [TAG_W-1:0]  tag_renew;
  logic [DATA_W-1:0] data_renew;

  modport master (
    output alu_valid, lsb_valid, br_valid,
    output alu_tag, lsb_tag, br_tag,
    output alu_data, lsb_data, br_data,
    input  alu_ready, lsb_ready, br_ready,
    input  tag_renew, data_renew
  );

  modport slave (
    input  alu_valid, lsb_valid, br_valid,
    input  alu_tag, lsb_tag, br_tag,
    input  alu_data, lsb_data, br_data,
    output alu_ready, lsb_ready, br_ready,
    output tag_renew, data_renew
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding FIFO per source (ALU, LSB, BR), round-robin
// grant of one FIFO head per cycle onto a registered tag/data broadcast.
module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input logic clk,
  input logic rst,
  input logic rdy,
  input logic clear,
  cdb_if.slave bus
);
  localparam int NSRC = 3;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  logic [NSRC-1:0]   src_valid;
  logic [TAG_W-1:0]  src_tag  [NSRC];
  logic [DATA_W-1:0] src_data [NSRC];

  logic [TAG_W-1:0]  tag_mem_q  [NSRC][DEPTH];
  logic [DATA_W-1:0] data_mem_q [NSRC][DEPTH];
  logic [PW-1:0]     rd_ptr_q   [NSRC];
  logic [PW-1:0]     wr_ptr_q   [NSRC];
  logic [CW-1:0]     cnt_q      [NSRC];
  logic [1:0]        rr_q, rr_d;
  logic [TAG_W-1:0]  tag_renew_q;
  logic [DATA_W-1:0] data_renew_q;

  logic [NSRC-1:0]   can_push, push, pop, non_empty;
  logic              grant_valid;
  logic [1:0]        grant;
  logic [TAG_W-1:0]  head_tag;
  logic [DATA_W-1:0] head_data;

  assign src_valid   = {bus.br_valid, bus.lsb_valid, bus.alu_valid};
  assign src_tag[0]  = bus.alu_tag;
  assign src_tag[1]  = bus.lsb_tag;
  assign src_tag[2]  = bus.br_tag;
  assign src_data[0] = bus.alu_data;
  assign src_data[1] = bus.lsb_data;
  assign src_data[2] = bus.br_data;

  // rst only gates the visible ready; internally the async reset already holds all state.
  assign bus.alu_ready  = rst & can_push[0];
  assign bus.lsb_ready  = rst & can_push[1];
  assign bus.br_ready   = rst & can_push[2];
  assign bus.tag_renew  = tag_renew_q;
  assign bus.data_renew = data_renew_q;

  always_comb begin
    can_push  = '0;
    push      = '0;
    non_empty = '0;
    for (int i = 0; i < NSRC; i++) begin
      can_push[i]  = rdy && !clear && (cnt_q[i] < CW'(DEPTH));
      push[i]      = src_valid[i] && can_push[i] && (src_tag[i] != '0);
      non_empty[i] = (cnt_q[i] != '0);
    end
  end

  // Round-robin search starting at rr_q, wrapping 2 -> 0.
  always_comb begin
    logic [2:0] cand;
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int k = 0; k < NSRC; k++) begin
      cand = {1'b0, rr_q} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!grant_valid && non_empty[cand[1:0]]) begin
        grant_valid = 1'b1;
        grant       = cand[1:0];
      end
    end
  end

  always_comb begin
    pop       = '0;
    rr_d      = rr_q;
    head_tag  = tag_mem_q[grant][rd_ptr_q[grant]];
    head_data = data_mem_q[grant][rd_ptr_q[grant]];
    if (grant_valid) begin
      pop[grant] = rdy && !clear;
      rr_d       = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]]  <= src_tag[i];
        data_mem_q[i][wr_ptr_q[i]] <= src_data[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q         <= '0;
      tag_renew_q  <= '0;
      data_renew_q <= '0;
      for (int i = 0; i < NSRC; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else if (rdy) begin
      if (clear) begin
        rr_q        <= '0;
        tag_renew_q <= '0;
        for (int i = 0; i < NSRC; i++) begin
          rd_ptr_q[i] <= '0;
          wr_ptr_q[i] <= '0;
          cnt_q[i]    <= '0;
        end
      end else begin
        rr_q        <= rr_d;
        tag_renew_q <= grant_valid ? head_tag : '0;
        if (grant_valid) data_renew_q <= head_data;
        for (int i = 0; i < NSRC; i++) begin
          if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
          if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
          cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: per-cycle vector table plus hand-written
// sequences for round-robin fairness, flush and asynchronous reset.
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic clear;

  cdb_if bus ();

  cdb_arbiter #(.TAG_W(4), .DATA_W(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  v;
    logic [3:0]  t0, t1, t2;
    logic [31:0] d0;
    logic        clr;
    logic        en;
    logic [2:0]  exp_rdy;
    logic [3:0]  exp_tag;
    logic [31:0] exp_data;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];
  logic [35:0] exp_q[$];

  function automatic vec_t mk(logic [2:0] v, logic [3:0] t0, logic [3:0] t1, logic [3:0] t2,
                              logic [31:0] d0, logic clr, logic en, logic [2:0] er,
                              logic [3:0] et, logic [31:0] ed);
    vec_t r;
    r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2; r.d0 = d0; r.clr = clr; r.en = en;
    r.exp_rdy = er; r.exp_tag = et; r.exp_data = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                       input logic [3:0] t2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input logic clr, input logic en);
    bus.alu_valid = v[0]; bus.lsb_valid = v[1]; bus.br_valid = v[2];
    bus.alu_tag = t0; bus.lsb_tag = t1; bus.br_tag = t2;
    bus.alu_data = d0; bus.lsb_data = d1; bus.br_data = d2;
    clear = clr; rdy = en;
  endtask

  task automatic cyc(input logic [2:0] v, input logic [3:0] t0, input logic [3:0] t1,
                     input logic [3:0] t2, input logic [31:0] d0, input logic clr);
    @(negedge clk);
    drive(v, t0, t1, t2, d0, 32'hB000_0000 | 32'(t1), 32'hC000_0000 | 32'(t2), clr, 1'b1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] src_data(input logic [3:0] t);
    if (t < 4'd6)       return 32'hA000_0000 | 32'(t);
    else if (t < 4'd11) return 32'hB000_0000 | 32'(t);
    else                return 32'hC000_0000 | 32'(t);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] ai, li, bi;
    logic [2:0] acc;
    logic [35:0] e;
    int gcnt [3];

    rst = 1'b0;
    drive(3'b111, 4'd1, 4'd2, 4'd3, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #12;
    check("reset_tag", bus.tag_renew, 0);
    check("reset_data", bus.data_renew, 0);
    check("reset_ready", {bus.br_ready, bus.lsb_ready, bus.alu_ready}, 0);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // Per-cycle table: inputs applied before an edge, ready checked before it, broadcast after it.
    vecs.push_back(mk(3'b001, 5, 0, 0, 32'h1234, 0, 1, 3'b111, 0, 32'h0));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 5, 32'h1234));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 0, 32'h1234));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    1, 1, 3'b000, 0, 32'h1234));
    vecs.push_back(mk(3'b111, 1, 2, 3, 32'hA1,   0, 1, 3'b111, 0, 32'h1234));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 1, 32'hA1));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 2, 32'hB000_0002));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 3, 32'hC000_0003));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 0, 32'hC000_0003));
    vecs.push_back(mk(3'b111, 8, 4, 9, 32'hA8,   0, 1, 3'b111, 0, 32'hC000_0003));
    vecs.push_back(mk(3'b010, 0, 5, 0, 32'h0,    0, 1, 3'b111, 8, 32'hA8));
    vecs.push_back(mk(3'b010, 0, 6, 0, 32'h0,    0, 1, 3'b101, 4, 32'hB000_0004));
    vecs.push_back(mk(3'b010, 0, 6, 0, 32'h0,    0, 1, 3'b111, 9, 32'hC000_0009));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b101, 5, 32'hB000_0005));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 6, 32'hB000_0006));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 0, 32'hB000_0006));
    vecs.push_back(mk(3'b001, 0, 0, 0, 32'hDEAD, 0, 1, 3'b111, 0, 32'hB000_0006));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 0, 32'hB000_0006));
    vecs.push_back(mk(3'b011, 7, 3, 0, 32'hA7,   0, 1, 3'b111, 0, 32'hB000_0006));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 7, 32'hA7));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 0, 3'b000, 7, 32'hA7));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 3, 32'hB000_0003));
    vecs.push_back(mk(3'b000, 0, 0, 0, 32'h0,    0, 1, 3'b111, 0, 32'hB000_0003));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].d0,
            32'hB000_0000 | 32'(vecs[i].t1), 32'hC000_0000 | 32'(vecs[i].t2),
            vecs[i].clr, vecs[i].en);
      #1;
      check($sformatf("vec%0d_ready", i), {bus.br_ready, bus.lsb_ready, bus.alu_ready},
            vecs[i].exp_rdy);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_tag", i), bus.tag_renew, vecs[i].exp_tag);
      check($sformatf("vec%0d_data", i), bus.data_renew, vecs[i].exp_data);
    end

    // Fairness: every source always has work; grants must rotate ALU, LSB, BR without bubbles.
    cyc(3'b000, 0, 0, 0, 0, 1'b1);
    foreach (gcnt[k]) gcnt[k] = 0;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back({4'(1 + k),  src_data(4'(1 + k))});
      exp_q.push_back({4'(6 + k),  src_data(4'(6 + k))});
      exp_q.push_back({4'(11 + k), src_data(4'(11 + k))});
    end
    ai = 0; li = 0; bi = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      drive({bi < 4, li < 4, ai < 4}, 4'd1 + ai, 4'd6 + li, 4'd11 + bi,
            src_data(4'd1 + ai), src_data(4'd6 + li), src_data(4'd11 + bi), 1'b0, 1'b1);
      #1;
      acc = {bus.br_valid & bus.br_ready, bus.lsb_valid & bus.lsb_ready,
             bus.alu_valid & bus.alu_ready};
      @(posedge clk);
      #1;
      if (acc[0]) ai++;
      if (acc[1]) li++;
      if (acc[2]) bi++;
      if (c == 0) begin
        check("rr_first_edge_tag", bus.tag_renew, 0);
      end else if (exp_q.size() == 0) begin
        check($sformatf("rr_cycle%0d_queue_empty", c), 1, 0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rr_cycle%0d_tag", c), bus.tag_renew, e[35:32]);
        check($sformatf("rr_cycle%0d_data", c), bus.data_renew, e[31:0]);
        if (c <= 9) begin
          if (bus.tag_renew >= 4'd1 && bus.tag_renew <= 4'd5) gcnt[0]++;
          else if (bus.tag_renew >= 4'd6 && bus.tag_renew <= 4'd10) gcnt[1]++;
          else if (bus.tag_renew >= 4'd11) gcnt[2]++;
        end
      end
    end
    check("rr_alu_grants", gcnt[0], 3);
    check("rr_lsb_grants", gcnt[1], 3);
    check("rr_br_grants", gcnt[2], 3);
    check("rr_left_over", exp_q.size(), 0);

    // Flush with several results buffered.
    cyc(3'b000, 0, 0, 0, 0, 1'b0);
    cyc(3'b111, 1, 2, 3, 32'hA000_0001, 1'b0);
    check("flush_pre_tag0", bus.tag_renew, 0);
    cyc(3'b111, 4, 5, 6, 32'hA000_0004, 1'b0);
    check("flush_pre_tag1", bus.tag_renew, 1);
    cyc(3'b111, 7, 8, 9, 32'hA000_0007, 1'b1);
    check("flush_tag", bus.tag_renew, 0);
    check("flush_data_hold", bus.data_renew, 32'hA000_0001);
    for (int c = 0; c < 5; c++) begin
      cyc(3'b000, 0, 0, 0, 0, 1'b0);
      check($sformatf("flush_after%0d_tag", c), bus.tag_renew, 0);
    end

    // Asynchronous reset between edges while results are buffered.
    cyc(3'b111, 2, 3, 4, 32'hA000_0002, 1'b0);
    cyc(3'b000, 0, 0, 0, 0, 1'b0);
    check("arst_pre_tag", bus.tag_renew, 2);
    #2;
    rst = 1'b0;
    #1;
    check("arst_tag", bus.tag_renew, 0);
    check("arst_data", bus.data_renew, 0);
    check("arst_ready", {bus.br_ready, bus.lsb_ready, bus.alu_ready}, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc(3'b000, 0, 0, 0, 0, 1'b0);
      check($sformatf("arst_after%0d_tag", c), bus.tag_renew, 0);
    end
    cyc(3'b001, 7, 0, 0, 32'h77, 1'b0);
    check("arst_push_tag", bus.tag_renew, 0);
    cyc(3'b000, 0, 0, 0, 0, 1'b0);
    check("arst_bcast_tag", bus.tag_renew, 7);
    check("arst_bcast_data", bus.data_renew, 32'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
